// File: rtl/jtcps1_fbwr_if.sv
// Frame-buffer line write port: one word per line_wr/line_wr_ok handshake.
interface jtcps1_fbwr_if #(parameter int DW = 12);
   logic [DW-1:0] line_data;
   logic [8:0]    line_addr;
   logic [8:0]    line_row;
   logic          line_wr;
   logic          line_wr_ok;

   modport master (output line_data, line_addr, line_row, line_wr, input line_wr_ok);
   modport slave  (input line_data, line_addr, line_row, line_wr, output line_wr_ok);
endinterface

// File: rtl/jtcps1_fbwr.sv
// CPS1 frame-buffer line writer. Pixels of each visible line are captured
// into one half of a ping-pong line buffer; during the next line the other
// half is drained to the frame buffer one word per handshake.
module jtcps1_fbwr #(
   parameter int DW   = 12,
   parameter int HLEN = 384
)(
   input  logic          clk,
   input  logic          rstn,
   input  logic          pxl_cen,
   input  logic          LHBL,
   input  logic          LVBL,
   input  logic [8:0]    vdump,
   input  logic [DW-1:0] pxl_data,
   jtcps1_fbwr_if.master fb,
   output logic          busy,
   output logic          overrun
);

   localparam logic [8:0] HLEN_C = 9'(HLEN);

   typedef enum logic [1:0] { IDLE, RD, WAIT, REQ } state_t;

   state_t        st;
   logic [DW-1:0] mem [0:1023];
   logic [DW-1:0] rd_q;
   logic          wbank;
   logic          lhbl_l;
   logic          lvbl_l;
   logic [8:0]    wr_cnt;
   logic [8:0]    rd_cnt;
   logic [8:0]    drain_len;
   logic [8:0]    row_cap;
   logic          line_end;
   logic          pxl_wr;
   logic          start;
   logic          drop;

   // LHBL has already fallen when line_end is seen, so capture and line end never coincide
   assign line_end = lhbl_l & ~LHBL;
   assign pxl_wr   = pxl_cen & LHBL & LVBL & (wr_cnt != HLEN_C);
   assign start    = line_end && (wr_cnt != 9'd0) && (st == IDLE);
   assign drop     = line_end && (wr_cnt != 9'd0) && (st != IDLE);

   // Capture side: pixel counter, bank select, row latch and sticky overrun flag
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wbank   <= 1'b0;
         wr_cnt  <= 9'd0;
         row_cap <= 9'd0;
         lhbl_l  <= 1'b0;
         lvbl_l  <= 1'b0;
         overrun <= 1'b0;
      end else begin
         lhbl_l <= LHBL;
         lvbl_l <= LVBL;
         if (line_end) begin
            if (start) wbank <= ~wbank;
            wr_cnt <= 9'd0;
         end else if (pxl_wr) begin
            if (wr_cnt == 9'd0) row_cap <= vdump;
            wr_cnt <= wr_cnt + 9'd1;
         end
         if (drop)
            overrun <= 1'b1;
         else if (LVBL && !lvbl_l)
            overrun <= 1'b0;
      end
   end

   // Line buffer write port; bank bit is the address MSB
   always_ff @(posedge clk) begin
      if (pxl_wr) mem[{wbank, wr_cnt}] <= pxl_data;
   end

   // Line buffer read port, one clock latency, always the bank not being written
   always_ff @(posedge clk) begin
      if (st == RD) rd_q <= mem[{~wbank, rd_cnt}];
   end

   // Drain FSM: read, wait for RAM, then hold the request until accepted
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st           <= IDLE;
         busy         <= 1'b0;
         rd_cnt       <= 9'd0;
         drain_len    <= 9'd0;
         fb.line_wr   <= 1'b0;
         fb.line_data <= '0;
         fb.line_addr <= 9'd0;
         fb.line_row  <= 9'd0;
      end else begin
         case (st)
            IDLE: begin
               if (start) begin
                  drain_len   <= wr_cnt;
                  fb.line_row <= row_cap;
                  rd_cnt      <= 9'd0;
                  busy        <= 1'b1;
                  st          <= RD;
               end
            end
            RD:   st <= WAIT;
            WAIT: begin
               fb.line_data <= rd_q;
               fb.line_addr <= rd_cnt;
               fb.line_wr   <= 1'b1;
               st           <= REQ;
            end
            REQ: begin
               if (fb.line_wr_ok) begin
                  fb.line_wr <= 1'b0;
                  rd_cnt     <= rd_cnt + 9'd1;
                  if (rd_cnt + 9'd1 == drain_len) begin
                     busy <= 1'b0;
                     st   <= IDLE;
                  end else begin
                     st <= RD;
                  end
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtcps1_fbwr.sv
// Randomised bench for jtcps1_fbwr with a line-level reference model.
module tb_jtcps1_fbwr;
   localparam int DW   = 12;
   localparam int HLEN = 384;

   logic          clk = 1'b0;
   logic          rstn;
   logic          pxl_cen;
   logic          LHBL;
   logic          LVBL;
   logic [8:0]    vdump;
   logic [DW-1:0] pxl_data;
   logic          busy;
   logic          overrun;

   jtcps1_fbwr_if #(.DW(DW)) fb ();

   jtcps1_fbwr #(.DW(DW), .HLEN(HLEN)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .pxl_cen  (pxl_cen),
      .LHBL     (LHBL),
      .LVBL     (LVBL),
      .vdump    (vdump),
      .pxl_data (pxl_data),
      .fb       (fb.master),
      .busy     (busy),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         n_wr    = 0;
   int         last_addr = -1;
   int         ok_mode = 0;
   int         ok_cyc  = 0;
   logic       exp_ovr = 1'b0;
   logic [29:0] expq[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // frame buffer acceptance pattern
   initial begin
      fb.line_wr_ok = 1'b0;
      forever begin
         @(posedge clk); #1;
         ok_cyc++;
         case (ok_mode)
            0:       fb.line_wr_ok = 1'b1;
            1:       fb.line_wr_ok = (ok_cyc % 10 == 0);
            default: fb.line_wr_ok = 1'b0;
         endcase
      end
   end

   // every presented word must match the head of the expected stream
   always @(negedge clk) begin
      if (rstn && fb.line_wr) begin
         if (expq.size() == 0) begin
            chk("spurious_wr", 32'(fb.line_wr), 32'd0);
         end else begin
            chk("word", 32'({fb.line_row, fb.line_addr, fb.line_data}), 32'(expq[0]));
            if (fb.line_wr_ok) begin
               last_addr = int'(fb.line_addr);
               n_wr++;
               void'(expq.pop_front());
            end
         end
      end
   end

   task automatic set_lvbl(input logic v);
      if (v && !LVBL) exp_ovr = 1'b0;
      LVBL = v;
      repeat (4) @(posedge clk);
      #1;
   endtask

   // one horizontal line: npix pixel enables, LHBL drops right after the last one
   task automatic run_line(input int npix, input logic [8:0] row, input bit ramp);
      logic [DW-1:0] pix[$];
      int stored;
      pix = {};
      vdump = row;
      LHBL = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < npix; i++) begin
         pxl_data = ramp ? DW'(i) : DW'($urandom);
         pix.push_back(pxl_data);
         pxl_cen = 1'b1;
         @(posedge clk); #1;
         pxl_cen = 1'b0;
         if (i != npix - 1) begin
            @(posedge clk); #1;
         end
      end
      if (npix == 0) begin
         repeat (5) @(posedge clk);
         #1;
      end
      LHBL = 1'b0;
      stored = LVBL ? ((npix < HLEN) ? npix : HLEN) : 0;
      if (stored > 0) begin
         if (expq.size() != 0)
            exp_ovr = 1'b1;
         else
            for (int i = 0; i < stored; i++)
               expq.push_back({row, 9'(i), pix[i]});
      end
      repeat (20) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while ((busy || expq.size() != 0) && k < 20000) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_timeout"}, 32'(k < 20000), 32'd1);
      @(negedge clk);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_qlen"}, 32'(expq.size()), 32'd0);
   endtask

   task automatic line_test(input string tag, input int npix, input logic [8:0] row,
                            input bit ramp, input int exp_n);
      n_wr = 0;
      run_line(npix, row, ramp);
      wait_idle(tag);
      chk({tag, "_nwr"}, 32'(n_wr), 32'(exp_n));
      chk({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int k;
      rstn = 1'b0; pxl_cen = 1'b0; LHBL = 1'b0; LVBL = 1'b1;
      vdump = 9'd0; pxl_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_line_wr", 32'(fb.line_wr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_outs", 32'({fb.line_row, fb.line_addr, fb.line_data}), 32'd0);
      @(negedge clk) rstn = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // ramp line
      ok_mode = 0;
      line_test("ramp", 384, 9'h020, 1'b1, 384);
      chk("ramp_last", 32'(last_addr), 32'd383);

      // random lines
      for (int t = 0; t < 4; t++) begin
         n = $urandom_range(1, HLEN);
         line_test("rand", n, 9'($urandom_range(0, 511)), 1'b0, n);
      end

      // backpressure
      ok_mode = 1;
      line_test("bp", 384, 9'($urandom_range(0, 511)), 1'b0, 384);
      chk("bp_last", 32'(last_addr), 32'd383);
      ok_mode = 0;

      // overrun: first line stalls, second line dropped
      ok_mode = 2;
      n_wr = 0;
      run_line(40, 9'h030, 1'b0);
      run_line(30, 9'h031, 1'b0);
      chk("ovr_set", 32'(overrun), 32'(exp_ovr));
      chk("ovr_busy", 32'(busy), 32'd1);
      ok_mode = 0;
      wait_idle("ovr");
      chk("ovr_nwr", 32'(n_wr), 32'd40);
      chk("ovr_hold", 32'(overrun), 32'(exp_ovr));
      set_lvbl(1'b0);
      chk("ovr_vbl", 32'(overrun), 32'(exp_ovr));
      set_lvbl(1'b1);
      chk("ovr_clr", 32'(overrun), 32'(exp_ovr));

      // oversize line saturates
      line_test("big", 400, 9'h044, 1'b1, 384);
      chk("big_last", 32'(last_addr), 32'd383);

      // short line ending on a pixel enable
      line_test("short", 10, 9'h055, 1'b0, 10);
      chk("short_last", 32'(last_addr), 32'd9);

      // vertical blank: nothing captured
      set_lvbl(1'b0);
      line_test("vbl", 50, 9'h066, 1'b0, 0);
      set_lvbl(1'b1);

      // line without pixels
      line_test("empty", 0, 9'h077, 1'b0, 0);

      // asynchronous reset in the middle of a drain
      run_line(384, 9'h088, 1'b1);
      k = 0;
      while (!(fb.line_wr && fb.line_addr == 9'd100) && k < 5000) begin
         @(negedge clk);
         k++;
      end
      chk("arst_reach", 32'(k < 5000), 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_line_wr", 32'(fb.line_wr), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_overrun", 32'(overrun), 32'd0);
      chk("arst_outs", 32'({fb.line_row, fb.line_addr, fb.line_data}), 32'd0);
      expq.delete();
      exp_ovr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rstn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      line_test("post_rst", 20, 9'h099, 1'b0, 20);
      chk("post_rst_last", 32'(last_addr), 32'd19);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
